// File: rtl/noc_out_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | noc_out_arbiter                                                             |
// | Per-output switch allocator: packet-granular round-robin with wormhole lock.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module noc_out_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    tail,
    input  logic            out_ready,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] sel,
    output logic            out_valid,
    output logic            xfer,
    output logic            busy
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [SELW-1:0] c_last    = SELW'(N - 1);
    localparam logic [N-1:0]    c_one     = N'(1);
    localparam logic [SELW:0]   c_n_ext   = (SELW + 1)'(N);

    state_t          r_state;
    logic [SELW-1:0] r_ptr;
    logic [N-1:0]    r_gnt;
    logic [SELW-1:0] r_sel;
    logic            r_busy;

    logic [SELW:0]   w_idx;
    logic [SELW-1:0] w_win;
    logic            w_any;
    logic            w_tail_xfer;
    logic [SELW-1:0] w_ptr_next;

    // Round-robin scan starting at r_ptr; the first requester found wins.
    always_comb begin : p_arb
        w_idx = '0;
        w_win = r_ptr;
        w_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (SELW + 1)'(k);
            if (w_idx >= c_n_ext) begin
                w_idx = w_idx - c_n_ext;
            end
            if (!w_any && req[w_idx[SELW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[SELW-1:0];
            end
        end
    end

    always_comb begin : p_out
        out_valid   = |(r_gnt & req);
        xfer        = out_valid & out_ready;
        w_tail_xfer = xfer & tail[r_sel];
        w_ptr_next  = (r_sel == c_last) ? '0 : r_sel + SELW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin : p_fsm
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= c_one << w_win;
                        r_sel   <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // Grant is held until the tail leaves; sel keeps its value afterwards.
                    if (w_tail_xfer) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;

endmodule
`default_nettype wire
